// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM pipeline register: enables, stall encoding and bus widths.
package ex_mem_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned StallBus     = 6;
  localparam int unsigned CntBus       = 2;

  // Stall vector bit positions for the execute and memory stages.
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;

  localparam logic [RegBus-1:0]       ZeroWord   = '0;
  localparam logic [DoubleRegBus-1:0] ZeroDouble = '0;
  localparam logic [RegAddrBus-1:0]   NOPRegAddr = '0;
  localparam logic [CntBus-1:0]       ZeroCnt    = '0;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures write-back and HI/LO bundles and carries MADD/MSUB
// accumulation state across execute-stage stalls.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic                    mem_whilo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  logic [RegAddrBus-1:0]   r_wd;
  logic                    r_wreg;
  logic [RegBus-1:0]       r_wdata;
  logic [RegBus-1:0]       r_hi;
  logic [RegBus-1:0]       r_lo;
  logic                    r_whilo;
  logic [DoubleRegBus-1:0] r_hilo;
  logic [CntBus-1:0]       r_cnt;

  logic w_ex_stop;
  logic w_mem_stop;

  assign w_ex_stop  = (stall[StallEx] == Stop);
  assign w_mem_stop = (stall[StallMem] == Stop);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      r_wd    <= NOPRegAddr;
      r_wreg  <= WriteDisable;
      r_wdata <= ZeroWord;
      r_hi    <= ZeroWord;
      r_lo    <= ZeroWord;
      r_whilo <= WriteDisable;
      r_hilo  <= ZeroDouble;
      r_cnt   <= ZeroCnt;
    end else if (w_ex_stop && !w_mem_stop) begin
      // Bubble: memory sees a no-op while the accumulation survives the stall.
      r_wd    <= NOPRegAddr;
      r_wreg  <= WriteDisable;
      r_wdata <= ZeroWord;
      r_hi    <= ZeroWord;
      r_lo    <= ZeroWord;
      r_whilo <= WriteDisable;
      r_hilo  <= hilo_i;
      r_cnt   <= cnt_i;
    end else if (!w_ex_stop && !w_mem_stop) begin
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg;
      r_wdata <= ex_wdata;
      r_hi    <= ex_hi;
      r_lo    <= ex_lo;
      r_whilo <= ex_whilo;
      r_hilo  <= ZeroDouble;
      r_cnt   <= ZeroCnt;
    end else begin
      // Hold, including the never-driven mem-stop-without-ex-stop case.
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
  assign mem_whilo = r_whilo;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

endmodule
